// File: rtl/instr_fetch_queue.sv
// rtl/instr_fetch_queue.sv - fetch-to-decode instruction queue
//
// Purpose: buffers fetched {pc, instr} pairs in a DEPTH-entry FIFO and
// presents the head entry to decode. When empty, decode sees a canonical
// NOP with pc/pc+4 of zero, so no stale opcode reaches the decoder.
//
// Ports:
//   clk, reset      rising-edge clock, asynchronous active-high reset
//   flushF          redirect; empties the queue, overrides push/pop
//   instrF, pcF     fetched instruction and its PC
//   validF/readyF   fetch-side handshake (push)
//   instrD, pcD     head entry (NOP_INSTR / 0 when empty)
//   pcPlus4D        pcD + 4 with carry dropped (0 when empty)
//   validD/readyD   decode-side handshake (pop)
//   countQ          current occupancy
module instr_fetch_queue #(
  parameter int               DEPTH     = 4,
  parameter int               XLEN      = 32,
  parameter logic [XLEN-1:0]  NOP_INSTR = 32'h0000_0013
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flushF,
  input  logic [XLEN-1:0]            instrF,
  input  logic [XLEN-1:0]            pcF,
  input  logic                       validF,
  output logic                       readyF,
  output logic [XLEN-1:0]            instrD,
  output logic [XLEN-1:0]            pcD,
  output logic [XLEN-1:0]            pcPlus4D,
  output logic                       validD,
  input  logic                       readyD,
  output logic [$clog2(DEPTH+1)-1:0] countQ
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [XLEN-1:0] r_pc_mem    [DEPTH];
  logic [XLEN-1:0] r_instr_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  logic            w_push;
  logic            w_pop;
  logic [XLEN-1:0] w_head_pc;
  logic [XLEN-1:0] w_head_instr;

  // Handshake outputs come from the registered count only, so neither
  // side's request can ripple combinationally into the other's ready.
  assign readyF = (r_count != FULL_COUNT);
  assign validD = (r_count != '0);
  assign countQ = r_count;

  assign w_push = validF & readyF & ~flushF;
  assign w_pop  = validD & readyD & ~flushF;

  assign w_head_pc    = r_pc_mem[r_rd_ptr];
  assign w_head_instr = r_instr_mem[r_rd_ptr];

  assign instrD   = validD ? w_head_instr : NOP_INSTR;
  assign pcD      = validD ? w_head_pc : '0;
  assign pcPlus4D = validD ? (w_head_pc + XLEN'(4)) : '0;

  // Pointers and occupancy; pointers wrap naturally since DEPTH is 2^PW.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flushF) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage needs no reset: validD masks unwritten slots.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr]    <= pcF;
      r_instr_mem[r_wr_ptr] <= instrF;
    end
  end

endmodule
